// File: rtl/reg_file_pkg.sv
// Shared definitions for the multiport register file.
//  - XLEN_DEFAULT / REG_ZERO: default data width and the hardwired-zero register index.
//  - sel_wr_port(): finds the highest-index enabled write port targeting an address.
//    Both the storage update and the read bypass use it, so they always agree on which port wins.
//    Callers zero-pad their enables and addresses up to MAX_WR ports of MAX_AW bits.
package reg_file_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned REG_ZERO     = 0;
  localparam int unsigned MAX_WR       = 8;
  localparam int unsigned MAX_AW       = 16;
  localparam int unsigned WR_IDX_W     = $clog2(MAX_WR);

  typedef logic [MAX_AW-1:0]  addr_t;
  typedef addr_t [MAX_WR-1:0] waddr_vec_t;

  typedef struct packed {
    logic                hit;
    logic [WR_IDX_W-1:0] idx;
  } wr_sel_t;

  // Ascending scan: a later (higher-index) match overwrites an earlier one.
  function automatic wr_sel_t sel_wr_port(addr_t addr, logic [MAX_WR-1:0] en, waddr_vec_t waddr);
    wr_sel_t sel;
    sel = '0;
    if (addr != addr_t'(REG_ZERO)) begin
      for (int j = 0; j < MAX_WR; j++) begin
        if (en[j] && (waddr[j] == addr)) begin
          sel.hit = 1'b1;
          sel.idx = WR_IDX_W'(j);
        end
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/multiport_reg_file_if.sv
// Bus bundle for multiport_reg_file: read ports, write ports and the busy-set request.
//  master: issue/writeback side (drives addresses, write data, set requests).
//  slave : register file (drives rd_data, rd_busy).
interface multiport_reg_file_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned NUM_WR = 1
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [NUM_RD*AW-1:0]   rd_addr;
  logic [NUM_RD*XLEN-1:0] rd_data;
  logic [NUM_RD-1:0]      rd_busy;
  logic [NUM_WR-1:0]      wr_en;
  logic [NUM_WR*AW-1:0]   wr_addr;
  logic [NUM_WR*XLEN-1:0] wr_data;
  logic [NUM_WR-1:0]      wr_clr_busy;
  logic                   set_busy;
  logic [AW-1:0]          set_addr;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, wr_clr_busy, set_busy, set_addr,
    input  rd_data, rd_busy
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, wr_clr_busy, set_busy, set_addr,
    output rd_data, rd_busy
  );
endinterface

// File: rtl/reg_file_scoreboard.sv
// Per-register busy scoreboard.
//  clk, rst_n     : clock, asynchronous active-low reset
//  set_busy_i     : mark set_addr_i as having a pending producer
//  wr_en_i        : write enables; with wr_clr_busy_i they retire the producer of wr_addr_i
//  busy_o         : registered busy vector, bit 0 always 0
module reg_file_scoreboard #(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned NUM_WR = 1,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 set_busy_i,
  input  logic [AW-1:0]        set_addr_i,
  input  logic [NUM_WR-1:0]    wr_en_i,
  input  logic [NUM_WR-1:0]    wr_clr_busy_i,
  input  logic [NUM_WR*AW-1:0] wr_addr_i,
  output logic [DEPTH-1:0]     busy_o
);

  logic [DEPTH-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_en_i[j] && wr_clr_busy_i[j]) busy_d[wr_addr_i[j*AW +: AW]] = 1'b0;
    end
    // Applied after the clears: a new producer supersedes the retiring one.
    if (set_busy_i && (set_addr_i != '0)) busy_d[set_addr_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/multiport_reg_file.sv
// Parametrised integer register file: NUM_RD combinational read ports, NUM_WR synchronous write
// ports, x0 hardwired to zero, optional same-cycle write-to-read bypass, busy scoreboard.
//  clk   : rising-edge clock
//  rst_n : asynchronous active-low reset (clears registers and busy bits)
//  bus   : slave side of multiport_reg_file_if (read/write ports, busy set request)
module multiport_reg_file
  import reg_file_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEFAULT,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned NUM_WR = 1,
  parameter int unsigned BYPASS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multiport_reg_file_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [XLEN-1:0]   regs_q [DEPTH];
  logic [XLEN-1:0]   regs_d [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [MAX_WR-1:0] en_pad;
  waddr_vec_t        waddr_pad;
  wr_sel_t           wsel [DEPTH];
  wr_sel_t           rsel [NUM_RD];
  logic [AW-1:0]     ra   [NUM_RD];

  // Pad write ports to the package's fixed-size view; unused ports stay disabled.
  always_comb begin
    en_pad                = '0;
    en_pad[NUM_WR-1:0]    = bus.wr_en;
    waddr_pad             = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      waddr_pad[j] = addr_t'(bus.wr_addr[j*AW +: AW]);
    end
  end

  // Storage update: per register, the highest enabled port wins; x0 is never written.
  always_comb begin
    regs_d = regs_q;
    for (int r = 0; r < DEPTH; r++) begin
      wsel[r] = sel_wr_port(addr_t'(r), en_pad, waddr_pad);
      if (wsel[r].hit) regs_d[r] = bus.wr_data[int'(wsel[r].idx)*XLEN +: XLEN];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DEPTH; r++) regs_q[r] <= '0;
    end else begin
      for (int r = 0; r < DEPTH; r++) regs_q[r] <= regs_d[r];
    end
  end

  reg_file_scoreboard #(
    .DEPTH  (DEPTH),
    .NUM_WR (NUM_WR)
  ) u_scoreboard (
    .clk           (clk),
    .rst_n         (rst_n),
    .set_busy_i    (bus.set_busy),
    .set_addr_i    (bus.set_addr),
    .wr_en_i       (bus.wr_en),
    .wr_clr_busy_i (bus.wr_clr_busy),
    .wr_addr_i     (bus.wr_addr),
    .busy_o        (busy)
  );

  // Read muxes. Outputs are forced to zero while in reset so bypassed write data cannot leak.
  always_comb begin
    bus.rd_data = '0;
    bus.rd_busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      ra[i]   = bus.rd_addr[i*AW +: AW];
      rsel[i] = sel_wr_port(addr_t'(ra[i]), en_pad, waddr_pad);
      if (rst_n && (ra[i] != '0)) begin
        bus.rd_busy[i] = busy[ra[i]];
        if ((BYPASS != 0) && rsel[i].hit) begin
          bus.rd_data[i*XLEN +: XLEN] = bus.wr_data[int'(rsel[i].idx)*XLEN +: XLEN];
        end else begin
          bus.rd_data[i*XLEN +: XLEN] = regs_q[ra[i]];
        end
      end
    end
  end

endmodule

// File: tb/tb_multiport_reg_file.sv
module tb_multiport_reg_file;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  multiport_reg_file_if #(.XLEN(32), .DEPTH(32), .NUM_RD(2), .NUM_WR(2)) bus ();
  multiport_reg_file_if #(.XLEN(32), .DEPTH(32), .NUM_RD(2), .NUM_WR(2)) bus_nb ();

  multiport_reg_file #(
    .XLEN(32), .DEPTH(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(1)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Second instance without bypass sees identical stimulus.
  multiport_reg_file #(
    .XLEN(32), .DEPTH(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(0)
  ) u_dut_nb (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_nb)
  );

  assign bus_nb.rd_addr     = bus.rd_addr;
  assign bus_nb.wr_en       = bus.wr_en;
  assign bus_nb.wr_addr     = bus.wr_addr;
  assign bus_nb.wr_data     = bus.wr_data;
  assign bus_nb.wr_clr_busy = bus.wr_clr_busy;
  assign bus_nb.set_busy    = bus.set_busy;
  assign bus_nb.set_addr    = bus.set_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int p, input logic [4:0] a);
    bus.rd_addr[p*5 +: 5] = a;
  endtask

  task automatic set_wr(input int p, input logic en, input logic [4:0] a, input logic [31:0] d,
                        input logic clr);
    bus.wr_en[p]          = en;
    bus.wr_addr[p*5 +: 5] = a;
    bus.wr_data[p*32 +: 32] = d;
    bus.wr_clr_busy[p]    = clr;
  endtask

  function automatic logic [31:0] rd(input int p);
    return bus.rd_data[p*32 +: 32];
  endfunction

  function automatic logic [31:0] rd_nb(input int p);
    return bus_nb.rd_data[p*32 +: 32];
  endfunction

  initial begin
    checks      = 0;
    failures    = 0;
    rst_n       = 1'b0;
    bus.rd_addr = '0;
    bus.wr_en   = '0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.wr_clr_busy = '0;
    bus.set_busy = 1'b0;
    bus.set_addr = '0;
    set_rd(0, 5'd5);
    set_rd(1, 5'd31);
    #2;
    check("in_reset_rd0", rd(0), 32'h0);
    check("in_reset_busy", 32'(bus.rd_busy), 32'h0);
    #10 rst_n = 1'b1;
    step();

    // 1. Reset state and x0 behaviour
    set_rd(0, 5'd0);
    set_rd(1, 5'd31);
    #1;
    check("rst_rd_x0", rd(0), 32'h0);
    check("rst_rd_x31", rd(1), 32'h0);
    check("rst_busy", 32'(bus.rd_busy), 32'h0);
    set_wr(0, 1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0);
    #1;
    check("x0_bypass", rd(0), 32'h0);
    step();
    set_wr(0, 1'b0, 5'd0, 32'h0, 1'b0);
    #1;
    check("x0_after_write", rd(0), 32'h0);

    // 2. Basic write, bypass vs stored
    set_wr(0, 1'b1, 5'd1, 32'h7, 1'b0);
    set_rd(0, 5'd1);
    #1;
    check("x1_bypass", rd(0), 32'h7);
    check("x1_nobypass", rd_nb(0), 32'h0);
    step();
    set_wr(0, 1'b0, 5'd0, 32'h0, 1'b0);
    set_rd(1, 5'd1);
    #1;
    check("x1_stored_p1", rd(1), 32'h7);
    check("x1_stored_nb", rd_nb(1), 32'h7);

    // 3. Write conflict, highest port wins
    set_wr(0, 1'b1, 5'd5, 32'hAAAA, 1'b0);
    set_wr(1, 1'b1, 5'd5, 32'h5555, 1'b0);
    set_rd(0, 5'd5);
    #1;
    check("x5_conflict_bypass", rd(0), 32'h5555);
    check("x5_conflict_nb", rd_nb(0), 32'h0);
    step();
    set_wr(0, 1'b0, 5'd0, 32'h0, 1'b0);
    set_wr(1, 1'b0, 5'd0, 32'h0, 1'b0);
    #1;
    check("x5_conflict_stored", rd(0), 32'h5555);

    // 4. Busy set, then clear by write
    bus.set_busy = 1'b1;
    bus.set_addr = 5'd3;
    set_rd(1, 5'd3);
    #1;
    check("x3_busy_same_cycle", 32'(bus.rd_busy[1]), 32'h0);
    step();
    bus.set_busy = 1'b0;
    #1;
    check("x3_busy_set", 32'(bus.rd_busy[1]), 32'h1);
    set_wr(1, 1'b1, 5'd3, 32'h33, 1'b1);
    #1;
    check("x3_busy_until_edge", 32'(bus.rd_busy[1]), 32'h1);
    step();
    set_wr(1, 1'b0, 5'd0, 32'h0, 1'b0);
    #1;
    check("x3_busy_cleared", 32'(bus.rd_busy[1]), 32'h0);
    check("x3_data", rd(1), 32'h33);

    // 5. Set wins over clear; x0 never busy; clearing an idle register is harmless
    bus.set_busy = 1'b1;
    bus.set_addr = 5'd4;
    set_wr(0, 1'b1, 5'd4, 32'h44, 1'b1);
    set_wr(1, 1'b1, 5'd1, 32'h11, 1'b1);
    set_rd(0, 5'd4);
    set_rd(1, 5'd1);
    step();
    bus.set_addr = 5'd0;
    set_wr(0, 1'b0, 5'd0, 32'h0, 1'b0);
    set_wr(1, 1'b0, 5'd0, 32'h0, 1'b0);
    #1;
    check("x4_set_wins", 32'(bus.rd_busy[0]), 32'h1);
    check("x4_data", rd(0), 32'h44);
    check("x1_clear_idle", 32'(bus.rd_busy[1]), 32'h0);
    check("x1_data_11", rd(1), 32'h11);
    step();
    bus.set_busy = 1'b0;
    set_rd(1, 5'd0);
    #1;
    check("x0_never_busy", 32'(bus.rd_busy[1]), 32'h0);
    check("x4_still_busy", 32'(bus.rd_busy[0]), 32'h1);

    // 6. Fill x1..x31 with i*3, then an asynchronous mid-cycle reset pulse
    for (int i = 1; i < 32; i += 2) begin
      set_wr(0, 1'b1, 5'(i), 32'(i * 3), 1'b0);
      set_wr(1, (i + 1) < 32, 5'(i + 1), 32'((i + 1) * 3), 1'b0);
      if (i == 29) begin
        bus.set_busy = 1'b1;
        bus.set_addr = 5'd7;
      end else begin
        bus.set_busy = 1'b0;
      end
      step();
    end
    bus.set_busy = 1'b0;
    set_wr(0, 1'b0, 5'd0, 32'h0, 1'b0);
    set_wr(1, 1'b0, 5'd0, 32'h0, 1'b0);
    set_rd(0, 5'd31);
    set_rd(1, 5'd10);
    #1;
    check("fill_x31", rd(0), 32'd93);
    check("fill_x10", rd(1), 32'd30);
    set_rd(1, 5'd7);
    #1;
    check("fill_x7", rd(1), 32'd21);
    check("x7_busy", 32'(bus.rd_busy[1]), 32'h1);
    rst_n = 1'b0;
    #2;
    check("mid_rst_x31", rd(0), 32'h0);
    check("mid_rst_x7", rd(1), 32'h0);
    check("mid_rst_busy", 32'(bus.rd_busy), 32'h0);
    #1 rst_n = 1'b1;
    #1;
    check("post_rst_x31", rd(0), 32'h0);
    check("post_rst_x7", rd(1), 32'h0);
    check("post_rst_busy", 32'(bus.rd_busy), 32'h0);
    set_rd(1, 5'd4);
    #1;
    check("post_rst_x4_busy", 32'(bus.rd_busy[1]), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
